// File: rtl/isp_pkg.sv
// Shared constants and arithmetic helpers for the ISP pixel stages.
package isp_pkg;

  // Pixel latency from in_* to out_* in clock cycles.
  localparam int ISP_WB_LAT = 3;

  // Unity gain in the default Q4.8 gain format.
  localparam int ISP_UNITY_GAIN_Q8 = 256;

  // Unity gain for an arbitrary number of fractional bits.
  function automatic logic [31:0] isp_unity(input int frac);
    return 32'd1 << frac;
  endfunction

  // Round-half-up a fixed-point product by frac bits, then clamp to an unsigned bits-wide result.
  function automatic logic [31:0] isp_round_sat(input logic [31:0] p, input int frac, input int bits);
    logic [31:0] rnd;
    logic [31:0] q;
    logic [31:0] maxv;
    rnd  = (frac > 0) ? (32'd1 << (frac - 1)) : 32'd0;
    q    = (p + rnd) >> frac;
    maxv = (32'd1 << bits) - 32'd1;
    return (q > maxv) ? maxv : q;
  endfunction

endpackage

// File: rtl/isp_wb_chan.sv
// One colour channel of the white-balance pipe: black-level subtract, gain, round/saturate.
// Active settings are latched with the pixel at S1 and travel with it, so a commit never
// affects pixels already in flight.
module isp_wb_chan
  import isp_pkg::*;
#(
  parameter int BITS      = 8,
  parameter int GAIN_BITS = 12,
  parameter int GAIN_FRAC = 8
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic [BITS-1:0]      i_pix,
  input  logic [BITS-1:0]      i_blc,
  input  logic [GAIN_BITS-1:0] i_gain,
  input  logic                 i_bypass,
  input  logic                 i_href_s2,
  output logic [BITS-1:0]      o_pix
);

  localparam int PW = BITS + GAIN_BITS;

  logic [BITS-1:0]      r_c;
  logic [BITS-1:0]      r_raw1;
  logic [GAIN_BITS-1:0] r_gain1;
  logic                 r_byp1;

  logic [PW-1:0]        r_p;
  logic [BITS-1:0]      r_raw2;
  logic                 r_byp2;

  logic [BITS-1:0]      r_out;

  // S1: clamp-at-zero black level subtraction, capture the settings for this pixel.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_c     <= '0;
      r_raw1  <= '0;
      r_gain1 <= '0;
      r_byp1  <= 1'b0;
    end else begin
      r_c     <= (i_pix > i_blc) ? (i_pix - i_blc) : '0;
      r_raw1  <= i_pix;
      r_gain1 <= i_gain;
      r_byp1  <= i_bypass;
    end
  end

  // S2: full-precision unsigned product.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_p    <= '0;
      r_raw2 <= '0;
      r_byp2 <= 1'b0;
    end else begin
      r_p    <= {{GAIN_BITS{1'b0}}, r_c} * {{BITS{1'b0}}, r_gain1};
      r_raw2 <= r_raw1;
      r_byp2 <= r_byp1;
    end
  end

  // S3: round and saturate, or pass the raw pixel in bypass; blank outside the active line.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_out <= '0;
    end else if (!i_href_s2) begin
      r_out <= '0;
    end else if (r_byp2) begin
      r_out <= r_raw2;
    end else begin
      r_out <= BITS'(isp_round_sat(32'(r_p), GAIN_FRAC, BITS));
    end
  end

  assign o_pix = r_out;

endmodule

// File: rtl/isp_wb_gain.sv
// White-balance stage: shadowed configuration committed at frame start, three channel pipes,
// sync delay line and per-frame saturating R/G/B statistics for the AWB firmware.
module isp_wb_gain
  import isp_pkg::*;
#(
  parameter int BITS      = 8,
  parameter int GAIN_BITS = 12,
  parameter int GAIN_FRAC = 8,
  parameter int ACC_BITS  = 32
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic [GAIN_BITS-1:0] cfg_gain_r,
  input  logic [GAIN_BITS-1:0] cfg_gain_g,
  input  logic [GAIN_BITS-1:0] cfg_gain_b,
  input  logic [BITS-1:0]      cfg_blc,
  input  logic                 cfg_bypass,
  input  logic                 cfg_update,
  output logic                 cfg_pending,
  input  logic                 in_href,
  input  logic                 in_vsync,
  input  logic [BITS-1:0]      in_r,
  input  logic [BITS-1:0]      in_g,
  input  logic [BITS-1:0]      in_b,
  output logic                 out_href,
  output logic                 out_vsync,
  output logic [BITS-1:0]      out_r,
  output logic [BITS-1:0]      out_g,
  output logic [BITS-1:0]      out_b,
  output logic [ACC_BITS-1:0]  stat_r,
  output logic [ACC_BITS-1:0]  stat_g,
  output logic [ACC_BITS-1:0]  stat_b,
  output logic                 stat_valid
);

  localparam logic [GAIN_BITS-1:0] UNITY = GAIN_BITS'(isp_unity(GAIN_FRAC));

  // Saturating accumulate; the statistic pins at full scale instead of wrapping.
  function automatic logic [ACC_BITS-1:0] sat_add(input logic [ACC_BITS-1:0] a,
                                                  input logic [BITS-1:0]     b);
    logic [ACC_BITS:0] s;
    s = {1'b0, a} + {{(ACC_BITS + 1 - BITS){1'b0}}, b};
    return s[ACC_BITS] ? '1 : s[ACC_BITS-1:0];
  endfunction

  logic                  r_vs_d;
  logic                  r_pending;
  logic [GAIN_BITS-1:0]  r_gain [3];
  logic [BITS-1:0]       r_blc;
  logic                  r_bypass;

  logic [ISP_WB_LAT-1:0] r_href_d;
  logic [ISP_WB_LAT-1:0] r_vs_pipe;

  logic                  r_ovs_d;
  logic [ACC_BITS-1:0]   r_acc  [3];
  logic [ACC_BITS-1:0]   r_stat [3];
  logic                  r_stat_vld;

  logic                  w_edge;
  logic                  w_commit;
  logic                  w_oedge;
  logic [BITS-1:0]       w_in       [3];
  logic [GAIN_BITS-1:0]  w_cfg_gain [3];
  logic [BITS-1:0]       w_pix      [3];

  assign w_in[0]       = in_r;
  assign w_in[1]       = in_g;
  assign w_in[2]       = in_b;
  assign w_cfg_gain[0] = cfg_gain_r;
  assign w_cfg_gain[1] = cfg_gain_g;
  assign w_cfg_gain[2] = cfg_gain_b;

  // A commit happens on a frame edge if armed earlier or armed on that very cycle.
  assign w_edge   = in_vsync & ~r_vs_d;
  assign w_commit = w_edge & (r_pending | cfg_update);

  // Shadow configuration: arm on cfg_update, copy staged values at the frame boundary.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_vs_d    <= 1'b0;
      r_pending <= 1'b0;
      r_blc     <= '0;
      r_bypass  <= 1'b0;
      for (int i = 0; i < 3; i++) r_gain[i] <= UNITY;
    end else begin
      r_vs_d    <= in_vsync;
      r_pending <= w_edge ? 1'b0 : (r_pending | cfg_update);
      if (w_commit) begin
        r_blc    <= cfg_blc;
        r_bypass <= cfg_bypass;
        for (int i = 0; i < 3; i++) r_gain[i] <= w_cfg_gain[i];
      end
    end
  end

  // Sync delay line matching the pixel pipe depth.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_href_d  <= '0;
      r_vs_pipe <= '0;
    end else begin
      r_href_d  <= {r_href_d[ISP_WB_LAT-2:0], in_href};
      r_vs_pipe <= {r_vs_pipe[ISP_WB_LAT-2:0], in_vsync};
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_chan
    isp_wb_chan #(
      .BITS      (BITS),
      .GAIN_BITS (GAIN_BITS),
      .GAIN_FRAC (GAIN_FRAC)
    ) u_chan (
      .pclk      (pclk),
      .rst       (rst),
      .i_pix     (w_in[i]),
      .i_blc     (r_blc),
      .i_gain    (r_gain[i]),
      .i_bypass  (r_bypass),
      .i_href_s2 (r_href_d[ISP_WB_LAT-2]),
      .o_pix     (w_pix[i])
    );
  end

  assign out_href  = r_href_d[ISP_WB_LAT-1];
  assign out_vsync = r_vs_pipe[ISP_WB_LAT-1];
  assign out_r     = w_pix[0];
  assign out_g     = w_pix[1];
  assign out_b     = w_pix[2];

  // Frame edge as seen at the output side of the pipe.
  assign w_oedge = out_vsync & ~r_ovs_d;

  // Statistics: accumulate output pixels, publish and restart on each output frame edge.
  // A pixel coincident with the edge starts the new frame's sum.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_ovs_d    <= 1'b0;
      r_stat_vld <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_acc[i]  <= '0;
        r_stat[i] <= '0;
      end
    end else begin
      r_ovs_d    <= out_vsync;
      r_stat_vld <= w_oedge;
      for (int i = 0; i < 3; i++) begin
        if (w_oedge) begin
          r_stat[i] <= r_acc[i];
          r_acc[i]  <= out_href ? ACC_BITS'(w_pix[i]) : '0;
        end else if (out_href) begin
          r_acc[i]  <= sat_add(r_acc[i], w_pix[i]);
        end
      end
    end
  end

  assign cfg_pending = r_pending;
  assign stat_r      = r_stat[0];
  assign stat_g      = r_stat[1];
  assign stat_b      = r_stat[2];
  assign stat_valid  = r_stat_vld;

endmodule

// File: tb/tb_isp_wb_gain.sv
// Self-checking bench for isp_wb_gain: a frame-level reference model checked every cycle,
// plus directed literal checks for the key arithmetic and sequencing cases.
module tb_isp_wb_gain;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic [11:0] cfg_gain_r = 12'h100, cfg_gain_g = 12'h100, cfg_gain_b = 12'h100;
  logic [7:0]  cfg_blc    = 8'd0;
  logic        cfg_bypass = 1'b0;
  logic        cfg_update = 1'b0;
  logic        in_href    = 1'b0;
  logic        in_vsync   = 1'b0;
  logic [7:0]  in_r = 8'd0, in_g = 8'd0, in_b = 8'd0;

  logic        cfg_pending, out_href, out_vsync, stat_valid;
  logic [7:0]  out_r, out_g, out_b;
  logic [31:0] stat_r, stat_g, stat_b;

  logic        pend_q10, href_q10, vs_q10, sv_q10;
  logic [7:0]  r_q10, g_q10, b_q10;
  logic [9:0]  sr_q10, sg_q10, sb_q10;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  isp_wb_gain #(.BITS(8), .GAIN_BITS(12), .GAIN_FRAC(8), .ACC_BITS(32)) dut (
    .pclk(pclk), .rst(rst),
    .cfg_gain_r(cfg_gain_r), .cfg_gain_g(cfg_gain_g), .cfg_gain_b(cfg_gain_b),
    .cfg_blc(cfg_blc), .cfg_bypass(cfg_bypass), .cfg_update(cfg_update),
    .cfg_pending(cfg_pending),
    .in_href(in_href), .in_vsync(in_vsync), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_href(out_href), .out_vsync(out_vsync), .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .stat_r(stat_r), .stat_g(stat_g), .stat_b(stat_b), .stat_valid(stat_valid)
  );

  isp_wb_gain #(.BITS(8), .GAIN_BITS(12), .GAIN_FRAC(8), .ACC_BITS(10)) dut10 (
    .pclk(pclk), .rst(rst),
    .cfg_gain_r(cfg_gain_r), .cfg_gain_g(cfg_gain_g), .cfg_gain_b(cfg_gain_b),
    .cfg_blc(cfg_blc), .cfg_bypass(cfg_bypass), .cfg_update(cfg_update),
    .cfg_pending(pend_q10),
    .in_href(in_href), .in_vsync(in_vsync), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_href(href_q10), .out_vsync(vs_q10), .out_r(r_q10), .out_g(g_q10), .out_b(b_q10),
    .stat_r(sr_q10), .stat_g(sg_q10), .stat_b(sb_q10), .stat_valid(sv_q10)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit href; bit vs; int px[3]; } ent_t;

  ent_t    pipe [3];
  ent_t    m_cur, m_new;
  int      m_gain [3];
  int      m_blc;
  bit      m_byp, m_pend, m_vsd, m_ovsd, m_sv, m_fedge, m_oedge;
  longint  m_acc32 [3], m_st32 [3], m_acc10 [3], m_st10 [3];
  int      m_in [3], m_cg [3];

  function automatic int wb(int x, int gain, int blc, bit byp);
    int c, q;
    if (byp) return x;
    c = (x > blc) ? x - blc : 0;
    q = (c * gain + 128) / 256;
    return (q > 255) ? 255 : q;
  endfunction

  function automatic longint sat(longint v, longint maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  always @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        pipe[i].href = 0; pipe[i].vs = 0;
        for (int c = 0; c < 3; c++) pipe[i].px[c] = 0;
        m_gain[i] = 256; m_acc32[i] = 0; m_st32[i] = 0; m_acc10[i] = 0; m_st10[i] = 0;
      end
      m_blc = 0; m_byp = 0; m_pend = 0; m_vsd = 0; m_ovsd = 0; m_sv = 0;
    end else begin
      m_cur   = pipe[2];
      m_oedge = m_cur.vs && !m_ovsd;
      m_ovsd  = m_cur.vs;
      m_sv    = m_oedge;
      for (int c = 0; c < 3; c++) begin
        if (m_oedge) begin
          m_st32[c]  = m_acc32[c];
          m_st10[c]  = m_acc10[c];
          m_acc32[c] = m_cur.href ? m_cur.px[c] : 0;
          m_acc10[c] = m_cur.href ? m_cur.px[c] : 0;
        end else if (m_cur.href) begin
          m_acc32[c] = sat(m_acc32[c] + m_cur.px[c], 64'd4294967295);
          m_acc10[c] = sat(m_acc10[c] + m_cur.px[c], 64'd1023);
        end
      end
      m_in[0] = in_r; m_in[1] = in_g; m_in[2] = in_b;
      m_cg[0] = cfg_gain_r; m_cg[1] = cfg_gain_g; m_cg[2] = cfg_gain_b;
      m_new.href = in_href;
      m_new.vs   = in_vsync;
      for (int c = 0; c < 3; c++)
        m_new.px[c] = in_href ? wb(m_in[c], m_gain[c], m_blc, m_byp) : 0;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = m_new;
      m_fedge = in_vsync && !m_vsd;
      m_vsd   = in_vsync;
      if (m_fedge) begin
        if (m_pend || cfg_update) begin
          for (int c = 0; c < 3; c++) m_gain[c] = m_cg[c];
          m_blc = cfg_blc;
          m_byp = cfg_bypass;
        end
        m_pend = 0;
      end else if (cfg_update) begin
        m_pend = 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge pclk) begin
    chk("m_href",    out_href,    pipe[2].href);
    chk("m_vsync",   out_vsync,   pipe[2].vs);
    chk("m_out_r",   out_r,       pipe[2].px[0]);
    chk("m_out_g",   out_g,       pipe[2].px[1]);
    chk("m_out_b",   out_b,       pipe[2].px[2]);
    chk("m_pending", cfg_pending, m_pend);
    chk("m_svalid",  stat_valid,  m_sv);
    chk("m_stat_r",  stat_r,      m_st32[0]);
    chk("m_stat_g",  stat_g,      m_st32[1]);
    chk("m_stat_b",  stat_b,      m_st32[2]);
    chk("m10_out_g", g_q10,       pipe[2].px[1]);
    chk("m10_sval",  sv_q10,      m_sv);
    chk("m10_st_r",  sr_q10,      m_st10[0]);
    chk("m10_st_g",  sg_q10,      m_st10[1]);
    chk("m10_st_b",  sb_q10,      m_st10[2]);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic vs_pulse();
    in_vsync = 1'b1; step();
    in_vsync = 1'b0; step();
  endtask

  task automatic stage(input logic [11:0] gr, gg, gb, input logic [7:0] blc, input logic byp);
    cfg_gain_r = gr; cfg_gain_g = gg; cfg_gain_b = gb; cfg_blc = blc; cfg_bypass = byp;
  endtask

  task automatic commit(input logic [11:0] gr, gg, gb, input logic [7:0] blc, input logic byp);
    stage(gr, gg, gb, blc, byp);
    cfg_update = 1'b1; step();
    cfg_update = 1'b0;
    vs_pulse();
  endtask

  task automatic px_lit(input string nm, input logic h, input logic [7:0] r, g, b,
                        input logic [7:0] er, eg, eb);
    in_href = h; in_r = r; in_g = g; in_b = b;
    step();
    in_href = 1'b0;
    step();
    step();
    chk({nm, "_r"}, out_r, er);
    chk({nm, "_g"}, out_g, eg);
    chk({nm, "_b"}, out_b, eb);
  endtask

  task automatic wait_stat(input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (stat_valid) begin seen = 1; break; end
      step();
    end
    chk({nm, "_stat_timeout"}, seen, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset defaults
    step(); step(); step();
    chk("rst_out_r", out_r, 8'd0);
    chk("rst_href",  out_href, 1'b0);
    chk("rst_pend",  cfg_pending, 1'b0);
    chk("rst_stat",  stat_r, 32'd0);
    rst = 1'b0;
    step();

    // T1: unity defaults and single-pixel frame statistic
    vs_pulse();
    px_lit("t1", 1'b1, 8'd100, 8'd50, 8'd200, 8'd100, 8'd50, 8'd200);
    vs_pulse();
    wait_stat("t1");
    chk("t1_stat_r", stat_r, 32'd100);
    chk("t1_stat_g", stat_g, 32'd50);
    chk("t1_stat_b", stat_b, 32'd200);

    // T2: 1.5x red gain with rounding and saturation
    commit(12'h180, 12'h100, 12'h100, 8'd0, 1'b0);
    px_lit("t2a", 1'b1, 8'd101, 8'd60, 8'd7, 8'd152, 8'd60, 8'd7);
    px_lit("t2b", 1'b1, 8'd200, 8'd60, 8'd7, 8'd255, 8'd60, 8'd7);

    // T3: black level clamps at zero
    commit(12'h100, 12'h100, 12'h100, 8'd16, 1'b0);
    px_lit("t3", 1'b1, 8'd10, 8'd16, 8'd17, 8'd0, 8'd0, 8'd1);

    // T4: mid-frame update waits for the frame edge
    stage(12'h100, 12'h200, 12'h100, 8'd0, 1'b0);
    cfg_update = 1'b1; step(); cfg_update = 1'b0;
    chk("t4_pend_armed", cfg_pending, 1'b1);
    px_lit("t4_old", 1'b1, 8'd30, 8'd40, 8'd50, 8'd14, 8'd24, 8'd34);
    chk("t4_pend_hold", cfg_pending, 1'b1);
    vs_pulse();
    chk("t4_pend_clr", cfg_pending, 1'b0);
    px_lit("t4_new", 1'b1, 8'd30, 8'd40, 8'd50, 8'd30, 8'd80, 8'd50);
    stage(12'h100, 12'h100, 12'h100, 8'd0, 1'b0);
    cfg_update = 1'b1; in_vsync = 1'b1; step();
    cfg_update = 1'b0; in_vsync = 1'b0; step();
    chk("t4_coinc_pend", cfg_pending, 1'b0);
    px_lit("t4_coinc", 1'b1, 8'd30, 8'd40, 8'd50, 8'd30, 8'd40, 8'd50);

    // T5: bypass ignores gain and blc; href gating blanks output
    commit(12'h000, 12'h000, 12'h000, 8'd200, 1'b1);
    px_lit("t5_byp", 1'b1, 8'd123, 8'd45, 8'd250, 8'd123, 8'd45, 8'd250);
    px_lit("t5_gate", 1'b0, 8'd9, 8'd9, 8'd9, 8'd0, 8'd0, 8'd0);

    // T6: statistics saturate in the narrow instance
    commit(12'h100, 12'h100, 12'h100, 8'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      in_href = 1'b1; in_r = 8'd255; in_g = 8'd255; in_b = 8'd255;
      step();
    end
    in_href = 1'b0;
    step(); step(); step(); step();
    vs_pulse();
    wait_stat("t6");
    chk("t6_sat_r",  sr_q10, 10'd1023);
    chk("t6_sat_b",  sb_q10, 10'd1023);
    chk("t6_full_r", stat_r, 32'd2040);
    chk("t6_sv10",   sv_q10, 1'b1);
    step();
    chk("t6_sv_pulse", stat_valid, 1'b0);

    // randomized frames, including edge-coincident updates and one mid-run reset
    for (int f = 0; f < 16; f++) begin
      int len;
      len = $urandom_range(20, 60);
      for (int c = 0; c < len; c++) begin
        in_href = ($urandom_range(0, 9) < 7);
        in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
        if ($urandom_range(0, 19) == 0)
          stage(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 1023)),
                12'($urandom_range(0, 600)), 8'($urandom_range(0, 63)),
                ($urandom_range(0, 7) == 0));
        cfg_update = ($urandom_range(0, 29) == 0);
        step();
      end
      cfg_update = ($urandom_range(0, 2) == 0);
      in_href    = $urandom_range(0, 1);
      in_vsync   = 1'b1;
      step();
      cfg_update = 1'b0;
      in_vsync   = $urandom_range(0, 1);
      step();
      in_vsync   = 1'b0;
      if (f == 9) begin
        rst = 1'b1; step(); rst = 1'b0;
      end
    end
    in_href = 1'b0; cfg_update = 1'b0;
    step(); step(); step(); step();

    // mid-frame reset flushes pipeline, pending and active settings
    commit(12'h300, 12'h300, 12'h300, 8'd5, 1'b0);
    stage(12'h080, 12'h080, 12'h080, 8'd0, 1'b0);
    cfg_update = 1'b1; step(); cfg_update = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_href = 1'b1; in_r = 8'd90; in_g = 8'd91; in_b = 8'd92;
      step();
    end
    rst = 1'b1;
    step();
    chk("rmid_href",  out_href, 1'b0);
    chk("rmid_out_r", out_r, 8'd0);
    chk("rmid_out_b", out_b, 8'd0);
    chk("rmid_pend",  cfg_pending, 1'b0);
    chk("rmid_stat",  stat_g, 32'd0);
    rst = 1'b0;
    in_href = 1'b0;
    step();
    px_lit("rmid_dflt", 1'b1, 8'd100, 8'd50, 8'd200, 8'd100, 8'd50, 8'd200);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
